// File: rtl/mult_div_if.sv
// Handshake/data bundle between the ID/EX stage buffer and the multi-cycle
// multiply/divide engine, plus its result path toward the EX/M buffer.
interface mult_div_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             div_by_zero;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, result_lo, result_hi, div_by_zero
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, result_lo, result_hi, div_by_zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Signed multi-cycle multiply (radix-2 shift-add) / divide (restoring) engine.
// Works on magnitudes for WIDTH iterations, then applies sign correction in FIX.
module mult_div_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic       clk,
  input  logic       reset,
  mult_div_if.slave  bus
);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state, state_d;
  logic [W2-1:0]    acc;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             sign_a, sign_b, op_q;
  logic [CNT_W-1:0] cnt;
  logic             done_q, dbz_q;
  logic [WIDTH-1:0] res_lo_q, res_hi_q;

  logic             accept, div_zero, last_iter;
  logic [WIDTH-1:0] a_mag_in, b_mag_in;
  logic [W2-1:0]    acc_init;

  // flush outranks start while idle
  assign accept    = (state == IDLE) && bus.start && !bus.flush;
  assign div_zero  = bus.op && (bus.b == '0);
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    a_mag_in = bus.a[WIDTH-1] ? -bus.a : bus.a;
    b_mag_in = bus.b[WIDTH-1] ? -bus.b : bus.b;
    // multiply shifts the multiplier out of the low half; divide shifts the dividend
    acc_init = bus.op ? {{WIDTH{1'b0}}, a_mag_in} : {{WIDTH{1'b0}}, b_mag_in};
  end

  // One iteration step for each operation
  logic [WIDTH:0]   mul_sum;
  logic [W2:0]      mul_wide;
  logic [W2-1:0]    mul_next;
  logic [W2-1:0]    div_sh;
  logic [WIDTH:0]   div_trial;
  logic [W2-1:0]    div_next;

  always_comb begin
    mul_sum   = {1'b0, acc[W2-1:WIDTH]} + {1'b0, mag_a};
    mul_wide  = acc[0] ? {mul_sum, acc[WIDTH-1:0]} : {1'b0, acc};
    mul_next  = mul_wide[W2:1];
    div_sh    = acc << 1;
    div_trial = {1'b0, div_sh[W2-1:WIDTH]} - {1'b0, mag_b};
    // borrow means the trial subtraction failed: restore, quotient bit 0
    div_next  = div_trial[WIDTH] ? div_sh
                                 : {div_trial[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};
  end

  // Sign correction applied in FIX
  logic [W2-1:0]    prod_s;
  logic [WIDTH-1:0] quot_s, rem_s;

  always_comb begin
    prod_s = (sign_a ^ sign_b) ? -acc : acc;
    quot_s = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_s  = sign_a ? -acc[W2-1:WIDTH] : acc[W2-1:WIDTH];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept && !div_zero) state_d = CALC;
      CALC:    if (bus.flush)           state_d = IDLE;
               else if (last_iter)      state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      op_q     <= 1'b0;
      cnt      <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (div_zero) begin
            res_lo_q <= '1;
            res_hi_q <= bus.a;
            dbz_q    <= 1'b1;
            done_q   <= 1'b1;
          end else begin
            acc    <= acc_init;
            mag_a  <= a_mag_in;
            mag_b  <= b_mag_in;
            sign_a <= bus.a[WIDTH-1];
            sign_b <= bus.b[WIDTH-1];
            op_q   <= bus.op;
            cnt    <= '0;
          end
        end
        CALC: if (!bus.flush) begin
          acc <= op_q ? div_next : mul_next;
          cnt <= cnt + 1'b1;
        end
        FIX: if (!bus.flush) begin
          res_lo_q <= op_q ? quot_s : prod_s[WIDTH-1:0];
          res_hi_q <= op_q ? rem_s  : prod_s[W2-1:WIDTH];
          dbz_q    <= 1'b0;
          done_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state == CALC) || (state == FIX);
  assign bus.done        = done_q;
  assign bus.result_lo   = res_lo_q;
  assign bus.result_hi   = res_hi_q;
  assign bus.div_by_zero = dbz_q;
endmodule
